// File: rtl/add_share_arb.sv
// Round-robin sequencer sharing one adder among NREQ requesters; grant 1 cycle after req, result 1 cycle after grant.
// Requesters hold req until their gnt pulse; optional op_cnt statistics output under ADD_SHARE_STATS_EN.
module add_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int CW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       opa,
  input  logic [NREQ*W-1:0]       opb,
  output logic [NREQ-1:0]         gnt,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  input  logic [W:0]              add_f,
  output logic [W:0]              res,
  output logic                    res_vld,
  output logic [$clog2(NREQ)-1:0] res_id,
`ifdef ADD_SHARE_STATS_EN
  output logic [CW-1:0]           op_cnt,
`endif
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || CW < 1) begin : g_bad_param
    $error("add_share_arb: NREQ must be >= 2 and CW >= 1");
  end

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] win_oh;
  logic            found;

  // Search starts at ptr and wraps modulo NREQ, so non-power-of-2 counts rotate correctly.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      id      <= '0;
      gnt     <= '0;
      add_a   <= '0;
      add_b   <= '0;
      res     <= '0;
      res_vld <= 1'b0;
      res_id  <= '0;
      busy    <= 1'b0;
`ifdef ADD_SHARE_STATS_EN
      op_cnt  <= '0;
`endif
    end else begin
      gnt     <= '0;
      res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= win_oh;
            add_a <= opa[win*W +: W];
            add_b <= opb[win*W +: W];
            id    <= win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // add_a/add_b were registered at the grant edge, so add_f is settled now.
          res     <= add_f;
          res_id  <= id;
          res_vld <= 1'b1;
          ptr     <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
          busy    <= 1'b0;
          state   <= IDLE;
`ifdef ADD_SHARE_STATS_EN
          op_cnt  <= op_cnt + CW'(1);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios plus random traffic against a round-robin reference model.
module tb_add_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;
`ifdef ADD_SHARE_STATS_EN
  localparam int CW   = 2;
`else
  localparam int CW   = 8;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] opa, opb;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    add_a, add_b;
  logic [W:0]      add_f;
  logic [W:0]      res;
  logic            res_vld;
  logic [IDW-1:0]  res_id;
  logic            busy;
`ifdef ADD_SHARE_STATS_EN
  logic [CW-1:0]   op_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_vld = 0;
  bit mon_en = 0;
  int q_gid[$];
  int q_res[$];
  int q_cnt[$];

  always #5 clk = ~clk;

  // The shared adder itself.
  assign add_f = {1'b0, add_a} + {1'b0, add_b};

  add_share_arb #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_f(add_f), .res(res), .res_vld(res_vld),
    .res_id(res_id),
`ifdef ADD_SHARE_STATS_EN
    .op_cnt(op_cnt),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: each granted op occupies two cycles; the winner is the first
  // requester found rotating from just past the previously served one.
  int              m_start, m_cur, m_sum, e_res, e_id, e_cnt;
  bit              m_pend, e_vld, e_busy;
  logic [NREQ-1:0] e_gnt;
  int              e_a, e_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_start = 0; m_pend = 0; m_cur = 0; m_sum = 0;
      e_gnt = '0; e_a = 0; e_b = 0; e_res = 0; e_id = 0;
      e_vld = 0; e_busy = 0; e_cnt = 0;
    end else begin
      e_gnt = '0;
      e_vld = 0;
      if (m_pend) begin
        e_res = m_sum; e_id = m_cur; e_vld = 1; e_busy = 0;
        m_start = (m_cur + 1) % NREQ;
        m_pend = 0;
        e_cnt = (e_cnt + 1) % (1 << CW);
      end else if (req != 0) begin
        for (int k = 0; k < NREQ; k++)
          if (!m_pend && req[(m_start + k) % NREQ]) begin
            m_cur = (m_start + k) % NREQ;
            m_pend = 1;
          end
        e_gnt[m_cur] = 1'b1;
        e_a = int'(opa[m_cur*W +: W]);
        e_b = int'(opb[m_cur*W +: W]);
        m_sum = e_a + e_b;
        e_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("busy", 32'(busy), 32'(e_busy));
      check("res_vld", 32'(res_vld), 32'(e_vld));
      check("res", 32'(res), e_res);
      check("res_id", 32'(res_id), e_id);
      check("add_a", 32'(add_a), e_a);
      check("add_b", 32'(add_b), e_b);
`ifdef ADD_SHARE_STATS_EN
      check("op_cnt", 32'(op_cnt), e_cnt);
`endif
      for (int i = 0; i < NREQ; i++) if (gnt[i]) q_gid.push_back(i);
      if (res_vld) begin
        n_vld++;
        q_res.push_back(int'(res));
`ifdef ADD_SHARE_STATS_EN
        q_cnt.push_back(int'(op_cnt));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q_gid.delete();
    q_res.delete();
    q_cnt.delete();
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    opa[i*W +: W] = W'(a);
    opb[i*W +: W] = W'(b);
  endtask

  // Single request held until its grant pulse, then dropped.
  task automatic do_op(input string tag, input int i, input int a, input int b);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_ops(i, a, b);
    req = oh;
    step();
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    req = '0;
    step();
    check({tag, "_vld"}, 32'(res_vld), 32'd1);
    check({tag, "_res"}, 32'(res), a + b);
    check({tag, "_id"}, 32'(res_id), i);
    step();
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; req = '0; opa = '0; opb = '0;
    step();
    mon_en = 1;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    rst_n = 1'b1;

    // Single requester 2: 3 + 4.
    q_gid.delete(); q_res.delete();
    do_op("t1", 2, 3, 4);
    check("t1_order", q_gid.size(), 1);

    // All four held from reset: strict rotation.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, i, 1);
    req = 4'b1111;
    repeat (10) step();
    req = '0;
    step(); step();
    check("t2_nops", q_gid.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check("t2_gid", q_gid[k], k % NREQ);
      check("t2_res", q_res[k], (k % NREQ) + 1);
    end

    // Operand extremes.
    do_op("t3_max", 0, 7, 7);
    do_op("t3_zero", 0, 0, 0);

    // Reset while the op is in flight.
    do_reset();
    set_ops(1, 5, 2);
    req = 4'b0010;
    step();
    check("t4_gnt", 32'(gnt), 32'b0010);
    snap = n_vld;
    rst_n = 1'b0;
    req = '0;
    step();
    check("t4_gnt0", 32'(gnt), 32'd0);
    check("t4_busy0", 32'(busy), 32'd0);
    check("t4_a0", 32'(add_a), 32'd0);
    check("t4_b0", 32'(add_b), 32'd0);
    rst_n = 1'b1;
    step();
    check("t4_novld", n_vld, snap);
    do_op("t4_after", 1, 5, 2);

    // Two requesters held: wrap from 3 back to 0.
    do_reset();
    set_ops(0, 1, 1);
    set_ops(2, 2, 2);
    req = 4'b0101;
    repeat (8) step();
    req = '0;
    step(); step();
    check("t5_nops", q_gid.size(), 4);
    for (int k = 0; k < 4; k++) check("t5_gid", q_gid[k], (k % 2) * 2);

`ifdef ADD_SHARE_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) do_op("t6_op", k % NREQ, k, 1);
    check("t6_n", q_cnt.size(), 5);
    for (int k = 0; k < 5; k++) check("t6_cnt", q_cnt[k], (k + 1) % 4);
`endif

    // Random traffic; requesters keep operands stable while pending.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          set_ops(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
          req[i] = ($urandom_range(0, 1) == 1);
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_ops(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
          req[i] = 1'b1;
        end
      end
      if (c == 200) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    req = '0;
    repeat (3) step();
    check("rand_some_ops", 32'(n_vld > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
